// File: rtl/arbitro_vc_d_pkg.sv
// Shared definitions for the VC-to-destination scheduler: one-hot FSM
// encodings and default word geometry.
package arbitro_vc_d_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'b001,
      RUN   = 3'b010,
      DRAIN = 3'b100
   } state_t;

   localparam int BW_DEF       = 6;
   localparam int DEST_BIT_DEF = 4;
   localparam int MAX_CONS_DEF = 3;

endpackage

// File: rtl/arbitro_vc_d.sv
// Scheduler between virtual-channel FIFOs VC0/VC1 and destination FIFOs D0/D1.
// VC0 has priority, but VC1 is guaranteed a grant after MAX_CONS consecutive
// VC0 grants. Popped words travel a two-stage pipeline and are routed to D0
// or D1 by their destination bit.
module arbitro_vc_d
   import arbitro_vc_d_pkg::*;
#(
   parameter int BW       = BW_DEF,
   parameter int DEST_BIT = DEST_BIT_DEF,
   parameter int MAX_CONS = MAX_CONS_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          active_in,
   input  logic          vc0_empty,
   input  logic          vc1_empty,
   input  logic          vc0_almost_full,
   input  logic          vc1_almost_full,
   input  logic [BW-1:0] vc0_data,
   input  logic [BW-1:0] vc1_data,
   input  logic          d0_almost_full,
   input  logic          d1_almost_full,
   output logic          vc0_pop,
   output logic          vc1_pop,
   output logic          d0_push,
   output logic          d1_push,
   output logic [BW-1:0] d_data,
   output logic          mf_pause,
   output logic          idle_out
);

   localparam logic [2:0] MAXC = 3'(MAX_CONS);

   state_t        state, state_nx;
   logic          ok, grant0, grant1;
   logic [2:0]    cons_cnt, cons_cnt_nx;
   logic          vld_p1, src_p1;
   logic [BW-1:0] word_p1;

   // Grant selection: VC0 first unless it has hogged MAX_CONS grants while VC1 waits
   always_comb begin
      ok     = active_in & ~d0_almost_full & ~d1_almost_full & (state == RUN);
      grant0 = ok & ~vc0_empty & (vc1_empty | (cons_cnt < MAXC));
      grant1 = ok & ~grant0 & ~vc1_empty;
   end

   assign vc0_pop = reset & grant0;
   assign vc1_pop = reset & grant1;

   // Consecutive-VC0 counter; held when there is nothing to arbitrate
   always_comb begin
      cons_cnt_nx = cons_cnt;
      if (vc0_empty & vc1_empty)
         cons_cnt_nx = cons_cnt;
      else if (vc1_empty | grant1)
         cons_cnt_nx = 3'd0;
      else if (grant0 & (cons_cnt < MAXC))
         cons_cnt_nx = cons_cnt + 3'd1;
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (!reset)
         cons_cnt <= 3'd0;
      else
         cons_cnt <= cons_cnt_nx;
   end

   // Stage 1: remember that a pop happened and which VC supplies the word
   always_ff @(posedge clk) begin
      if (!reset) begin
         vld_p1 <= 1'b0;
         src_p1 <= 1'b0;
      end else begin
         vld_p1 <= grant0 | grant1;
         src_p1 <= grant1;
      end
   end

   assign word_p1 = src_p1 ? vc1_data : vc0_data;

   // Stage 2: capture the read word and raise a one-cycle push toward its destination
   always_ff @(posedge clk) begin
      if (!reset) begin
         d0_push <= 1'b0;
         d1_push <= 1'b0;
         d_data  <= '0;
      end else begin
         d0_push <= vld_p1 & ~word_p1[DEST_BIT];
         d1_push <= vld_p1 &  word_p1[DEST_BIT];
         if (vld_p1)
            d_data <= word_p1;
      end
   end

   // Status flags toward the main FIFO and control FSM
   always_ff @(posedge clk) begin
      if (!reset) begin
         mf_pause <= 1'b0;
         idle_out <= 1'b0;
      end else begin
         mf_pause <= vc0_almost_full | vc1_almost_full;
         idle_out <= (state == IDLE);
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // FSM next state: DRAIN lets in-flight words finish before going idle
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (active_in) state_nx = RUN;
         RUN:     if (!active_in) state_nx = DRAIN;
         DRAIN: begin
            if (active_in)
               state_nx = RUN;
            else if (!vld_p1 && !d0_push && !d1_push)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_arbitro_vc_d.sv
// Bench for arbitro_vc_d: emulates both VC FIFOs with queues and checks every
// cycle against a reference model of the scheduling rules.
module tb_arbitro_vc_d;

   localparam int BW = 6;
   localparam int DB = 4;
   localparam int MC = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          active_in = 1'b0;
   logic          vc0_empty = 1'b1, vc1_empty = 1'b1;
   logic          vc0_almost_full = 1'b0, vc1_almost_full = 1'b0;
   logic [BW-1:0] vc0_data = '0, vc1_data = '0;
   logic          d0_almost_full = 1'b0, d1_almost_full = 1'b0;
   logic          vc0_pop, vc1_pop, d0_push, d1_push, mf_pause, idle_out;
   logic [BW-1:0] d_data;

   arbitro_vc_d #(.BW(BW), .DEST_BIT(DB), .MAX_CONS(MC)) dut (
      .clk(clk), .reset(reset), .active_in(active_in),
      .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
      .vc0_almost_full(vc0_almost_full), .vc1_almost_full(vc1_almost_full),
      .vc0_data(vc0_data), .vc1_data(vc1_data),
      .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
      .vc0_pop(vc0_pop), .vc1_pop(vc1_pop), .d0_push(d0_push), .d1_push(d1_push),
      .d_data(d_data), .mf_pause(mf_pause), .idle_out(idle_out)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [BW-1:0] q0[$], q1[$];
   int            glog[$];

   typedef enum {M_IDLE, M_RUN, M_DRAIN} mstate_t;
   mstate_t       m_state = M_IDLE;
   int            m_cnt = 0;
   bit            m_pv = 0;
   logic [BW-1:0] m_pw = '0;
   bit            e_d0 = 0, e_d1 = 0, e_mf = 0, e_idle = 0;
   logic [BW-1:0] e_word = '0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check pops mid-cycle, advance FIFOs and model, check registered outputs
   task automatic step();
      bit e0, e1, ok, g0, g1, p0, p1, old_pv, old_push;
      logic [BW-1:0] w;
      @(negedge clk);
      vc0_empty = (q0.size() == 0);
      vc1_empty = (q1.size() == 0);
      e0 = vc0_empty;
      e1 = vc1_empty;
      #1;
      ok = reset && active_in && !d0_almost_full && !d1_almost_full && m_state == M_RUN;
      g0 = ok && !e0 && (e1 || m_cnt < MC);
      g1 = ok && !g0 && !e1;
      w  = g0 ? q0[0] : (g1 ? q1[0] : '0);
      chk("vc0_pop", 8'(vc0_pop), 8'(g0));
      chk("vc1_pop", 8'(vc1_pop), 8'(g1));
      p0 = vc0_pop;
      p1 = vc1_pop;
      if (p0) glog.push_back(0);
      if (p1) glog.push_back(1);

      @(posedge clk);
      #1;
      if (!reset) begin
         m_state = M_IDLE; m_cnt = 0; m_pv = 0; m_pw = '0;
         e_d0 = 0; e_d1 = 0; e_word = '0; e_mf = 0; e_idle = 0;
      end else begin
         old_pv   = m_pv;
         old_push = e_d0 || e_d1;
         e_idle = (m_state == M_IDLE);
         e_mf   = vc0_almost_full || vc1_almost_full;
         e_d0   = m_pv && !m_pw[DB];
         e_d1   = m_pv &&  m_pw[DB];
         if (m_pv) e_word = m_pw;
         m_pv = g0 || g1;
         m_pw = w;
         if (e0 && e1) m_cnt = m_cnt;
         else if (e1 || g1) m_cnt = 0;
         else if (g0) m_cnt = (m_cnt + 1 > MC) ? MC : m_cnt + 1;
         case (m_state)
            M_IDLE:  if (active_in) m_state = M_RUN;
            M_RUN:   if (!active_in) m_state = M_DRAIN;
            default: if (active_in) m_state = M_RUN;
                     else if (!old_pv && !old_push) m_state = M_IDLE;
         endcase
      end
      if (p0 && q0.size() > 0) vc0_data = q0.pop_front();
      else vc0_data = BW'($urandom);
      if (p1 && q1.size() > 0) vc1_data = q1.pop_front();
      else vc1_data = BW'($urandom);

      chk("d0_push",  8'(d0_push),  8'(e_d0));
      chk("d1_push",  8'(d1_push),  8'(e_d1));
      chk("d_data",   8'(d_data),   8'(e_word));
      chk("mf_pause", 8'(mf_pause), 8'(e_mf));
      chk("idle_out", 8'(idle_out), 8'(e_idle));
   endtask

   initial begin
      int pat[8];
      pat = '{0, 0, 0, 1, 0, 0, 0, 1};

      // 1: reset, then idle with active_in low
      reset = 1'b0;
      step(); step();
      chk("rst_d0_push", 8'(d0_push), 8'h00);
      chk("rst_d_data",  8'(d_data),  8'h00);
      reset = 1'b1;
      step(); step();
      chk("idle_after_rst", 8'(idle_out), 8'h01);

      // 2: two VC0 words routed to D0 then D1
      active_in = 1'b1;
      q0.push_back(6'h05);
      q0.push_back(6'h15);
      repeat (6) step();

      // 3: both VCs backlogged -> fairness pattern
      glog.delete();
      for (int i = 0; i < 10; i++) begin
         q0.push_back(BW'($urandom));
         q1.push_back(BW'($urandom));
      end
      repeat (8) step();
      for (int i = 0; i < 8; i++)
         chk($sformatf("grant_order_%0d", i), 8'(i < glog.size() ? glog[i] : 9), 8'(pat[i]));
      repeat (12) step();

      // 4: destination back-pressure stops pops, then resumes
      for (int i = 0; i < 6; i++) begin
         q0.push_back(BW'($urandom));
         q1.push_back(BW'($urandom));
      end
      d1_almost_full = 1'b1;
      repeat (4) step();
      d1_almost_full = 1'b0;
      repeat (14) step();

      // 5: active drop with words in flight -> drain to idle
      q0.push_back(6'h12);
      q0.push_back(6'h03);
      q0.push_back(6'h1f);
      step(); step();
      active_in = 1'b0;
      repeat (6) step();
      chk("idle_after_drain", 8'(idle_out), 8'h01);

      // randomized traffic
      active_in = 1'b1;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 2) == 0) q0.push_back(BW'($urandom));
         if ($urandom_range(0, 2) == 0) q1.push_back(BW'($urandom));
         d0_almost_full  = ($urandom_range(0, 7) == 0);
         d1_almost_full  = ($urandom_range(0, 7) == 0);
         vc0_almost_full = ($urandom_range(0, 5) == 0);
         vc1_almost_full = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 19) == 0) active_in = ~active_in;
         step();
      end
      d0_almost_full = 1'b0;
      d1_almost_full = 1'b0;
      vc0_almost_full = 1'b0;
      active_in = 1'b1;

      // 6: pause flag, then reset mid-stream discards in-flight words
      vc1_almost_full = 1'b1;
      for (int i = 0; i < 8; i++) q0.push_back(BW'($urandom) | 6'h10);
      step();
      chk("mf_pause_set", 8'(mf_pause), 8'h01);
      vc1_almost_full = 1'b0;
      step(); step();
      reset = 1'b0;
      step(); step();
      reset = 1'b1;
      active_in = 1'b0;
      repeat (5) step();
      chk("no_push_after_rst", 8'(d0_push | d1_push), 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
